// File: rtl/axis_governor_pkg.sv
// rtl/axis_governor_pkg.sv - shared command-word layout, FSM states and packer for the axis_governor family
package axis_governor_pkg;

    localparam int DEST_MSB = 63;
    localparam int DEST_LSB = 56;
    localparam int CNT_MSB  = 31;
    localparam int CNT_LSB  = 16;

    localparam int PAUSE  = 3;
    localparam int DROP   = 2;
    localparam int LOG    = 1;
    localparam int INJECT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD
    } gov_state_e;

    // flags is indexed by PAUSE/DROP/LOG/INJECT; cnt only travels with inject commands
    function automatic logic [63:0] pack_cmd(
        input logic [7:0]  dest,
        input logic [15:0] cnt,
        input logic [3:0]  flags
    );
        logic [63:0] w;
        w = '0;
        w[DEST_MSB:DEST_LSB] = dest;
        w[CNT_MSB:CNT_LSB]   = flags[INJECT] ? cnt : 16'd0;
        w[PAUSE]             = flags[PAUSE];
        w[DROP]              = flags[DROP];
        w[LOG]               = flags[LOG];
        w[INJECT]            = flags[INJECT];
        return w;
    endfunction

endpackage

// File: rtl/axis_governor_cmd_gen.sv
// rtl/axis_governor_cmd_gen.sv - command channel initiator: packs requests into cmd words and forwards inject payload
module axis_governor_cmd_gen
    import axis_governor_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_dest,
    input  logic [15:0]           req_cnt,
    input  logic                  req_pause,
    input  logic                  req_drop,
    input  logic                  req_log,
    input  logic                  req_inject,
    input  logic [DATA_WIDTH-1:0] inj_TDATA,
    input  logic                  inj_TVALID,
    output logic                  inj_TREADY,
    input  logic                  inj_TLAST,
    output logic [DATA_WIDTH-1:0] cmd_TDATA,
    output logic                  cmd_TVALID,
    input  logic                  cmd_TREADY,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_timeout,
    input  logic                  err_clr,
    output logic [15:0]           stat_cmds,
    output logic [31:0]           stat_flits
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    gov_state_e            state;
    logic [DATA_WIDTH-1:0] cmd_word;
    logic                  cmd_valid_q;
    logic                  req_ready_q;
    logic [15:0]           remaining;
    logic                  inject_q;
    logic [WAIT_W-1:0]     wait_cnt;

    assign busy      = (state != ST_IDLE);
    assign req_ready = req_ready_q;

    // Payload phase is a pure passthrough so the governor sees injection flits with no added latency
    always_comb begin
        cmd_TVALID = cmd_valid_q;
        cmd_TDATA  = cmd_word;
        inj_TREADY = 1'b0;
        if (state == ST_PAYLOAD) begin
            cmd_TVALID = inj_TVALID;
            cmd_TDATA  = inj_TDATA;
            inj_TREADY = cmd_TREADY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_word    <= '0;
            cmd_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            remaining   <= '0;
            inject_q    <= 1'b0;
            wait_cnt    <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            stat_cmds   <= '0;
            stat_flits  <= '0;
        end else begin
            // Clear first so a same-cycle error event below overrides it
            if (err_clr) begin
                err_len     <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        cmd_word    <= DATA_WIDTH'(pack_cmd(req_dest, req_cnt,
                                           {req_pause, req_drop, req_log, req_inject}));
                        remaining   <= req_cnt;
                        inject_q    <= req_inject;
                        wait_cnt    <= '0;
                        cmd_valid_q <= 1'b1;
                        req_ready_q <= 1'b0;
                        state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_TREADY) begin
                        cmd_valid_q <= 1'b0;
                        stat_cmds   <= stat_cmds + 16'd1;
                        if (inject_q && remaining != 16'd0) begin
                            state <= ST_PAYLOAD;
                        end else begin
                            state       <= ST_IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                        // Retracting TVALID is safe here: no governor matched dest
                        cmd_valid_q <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (inj_TVALID && cmd_TREADY) begin
                        remaining  <= remaining - 16'd1;
                        stat_flits <= stat_flits + 32'd1;
                        if ((remaining == 16'd1) != inj_TLAST) begin
                            err_len <= 1'b1;
                        end
                        if (remaining == 16'd1) begin
                            state       <= ST_IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_governor_cmd_gen.sv
// tb/tb_axis_governor_cmd_gen.sv - scoreboard bench for axis_governor_cmd_gen
module tb_axis_governor_cmd_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_dest;
    logic [15:0] req_cnt;
    logic        req_pause, req_drop, req_log, req_inject;
    logic [63:0] inj_TDATA;
    logic        inj_TVALID;
    logic        inj_TREADY;
    logic        inj_TLAST;
    logic [63:0] cmd_TDATA;
    logic        cmd_TVALID;
    logic        cmd_TREADY;
    logic        busy;
    logic        err_len;
    logic        err_timeout;
    logic        err_clr;
    logic [15:0] stat_cmds;
    logic [31:0] stat_flits;

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    axis_governor_cmd_gen #(.DATA_WIDTH(64), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_cnt(req_cnt),
        .req_pause(req_pause), .req_drop(req_drop), .req_log(req_log), .req_inject(req_inject),
        .inj_TDATA(inj_TDATA), .inj_TVALID(inj_TVALID), .inj_TREADY(inj_TREADY), .inj_TLAST(inj_TLAST),
        .cmd_TDATA(cmd_TDATA), .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout), .err_clr(err_clr),
        .stat_cmds(stat_cmds), .stat_flits(stat_flits)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: ready held 1, mode 1: toggles every cycle, mode 2: held 0
    task automatic set_mode(input int m);
        rdy_mode   = m;
        cmd_TREADY = (m != 2);
    endtask

    task automatic send_req(input logic [7:0] dest, input logic [15:0] cnt, input logic [3:0] flags,
                            input logic [63:0] word, input bit push);
        int n;
        req_dest = dest;
        req_cnt  = cnt;
        {req_pause, req_drop, req_log, req_inject} = flags;
        req_valid = 1'b1;
        if (push) exp_q.push_back(word);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        chk("req_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("cmd_valid_latency", cmd_TVALID, 1);
    endtask

    task automatic send_flit(input logic [63:0] data, input logic last);
        int n;
        inj_TDATA  = data;
        inj_TLAST  = last;
        inj_TVALID = 1'b1;
        exp_q.push_back(data);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inj_TREADY && n < 100);
        chk("inj_handshake", inj_TREADY, 1);
        @(posedge clk);
        #1;
        inj_TVALID = 1'b0;
        inj_TLAST  = 1'b0;
    endtask

    task automatic wait_idle(output bit saw_inj);
        int n;
        saw_inj = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            saw_inj = saw_inj | inj_TREADY;
            n++;
        end while ((busy || exp_q.size() != 0) && n < 200);
        chk("idle_reached", busy, 0);
        chk("sb_drained", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw;
        int vcnt;
        rst = 1'b1;
        req_valid = 1'b0; req_dest = '0; req_cnt = '0;
        {req_pause, req_drop, req_log, req_inject} = 4'b0;
        inj_TDATA = '0; inj_TVALID = 1'b0; inj_TLAST = 1'b0;
        cmd_TREADY = 1'b1; err_clr = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (cmd_TVALID && cmd_TREADY) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL cmd_beat_unexpected: got 0x%0h with empty scoreboard", cmd_TDATA);
                        end else begin
                            chk("cmd_beat", cmd_TDATA, exp_q.pop_front());
                        end
                    end
                end
            end
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    if (rdy_mode == 1) cmd_TREADY = ~cmd_TREADY;
                end
            end
            begin
                repeat (5000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog: bench did not complete within 5000 cycles");
            end
            begin
                #12;
                chk("rst_cmd_valid", cmd_TVALID, 0);
                chk("rst_cmd_data", cmd_TDATA, 0);
                chk("rst_inj_ready", inj_TREADY, 0);
                chk("rst_req_ready", req_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_errs", {err_len, err_timeout}, 0);
                chk("rst_stats", {stat_cmds, stat_flits}, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;

                // plain pause command
                set_mode(0);
                send_req(8'h05, 16'd7, 4'b1000, 64'h0500_0000_0000_0008, 1'b1);
                chk("busy_in_cmd", busy, 1);
                wait_idle(saw);
                chk("stat_cmds_1", stat_cmds, 1);

                // inject 3 flits with stalling ready
                set_mode(1);
                send_req(8'h02, 16'd3, 4'b0001, 64'h0200_0000_0003_0001, 1'b1);
                send_flit(64'hA, 1'b0);
                send_flit(64'hB, 1'b0);
                send_flit(64'hC, 1'b1);
                wait_idle(saw);
                chk("stat_flits_3", stat_flits, 3);
                chk("err_len_clean", err_len, 0);
                chk("stat_cmds_2", stat_cmds, 2);

                // early TLAST: both flits still forwarded, err_len latched
                set_mode(0);
                send_req(8'h03, 16'd2, 4'b0001, 64'h0300_0000_0002_0001, 1'b1);
                send_flit(64'h11, 1'b1);
                send_flit(64'h22, 1'b0);
                wait_idle(saw);
                chk("err_len_set", err_len, 1);
                chk("stat_flits_5", stat_flits, 5);
                err_clr = 1'b1;
                @(posedge clk);
                #1;
                err_clr = 1'b0;
                chk("err_len_cleared", err_len, 0);

                // timeout with ready held low
                set_mode(2);
                send_req(8'h07, 16'd0, 4'b0010, 64'h0700_0000_0000_0002, 1'b0);
                vcnt = 0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (!cmd_TVALID) break;
                    vcnt++;
                end
                chk("timeout_valid_cycles", 64'(vcnt), 16);
                chk("err_timeout_set", err_timeout, 1);
                chk("req_ready_after_timeout", req_ready, 1);
                chk("stat_cmds_unchanged", stat_cmds, 3);
                @(posedge clk);
                #1;

                // inject with cnt 0 sends only the command word
                set_mode(0);
                send_req(8'h09, 16'd0, 4'b0101, 64'h0900_0000_0000_0005, 1'b1);
                wait_idle(saw);
                chk("inj_ready_never", 64'(saw), 0);
                chk("stat_cmds_4", stat_cmds, 4);
                chk("stat_flits_still_5", stat_flits, 5);
                chk("err_timeout_sticky", err_timeout, 1);

                // reset in the middle of a payload
                send_req(8'h01, 16'd4, 4'b0001, 64'h0100_0000_0004_0001, 1'b1);
                send_flit(64'h100, 1'b0);
                inj_TDATA = 64'hDEAD;
                chk("mid_payload_busy", busy, 1);
                chk("mid_payload_inj_ready", inj_TREADY, 1);
                rst = 1'b1;
                #1;
                chk("mrst_cmd_valid", cmd_TVALID, 0);
                chk("mrst_cmd_data", cmd_TDATA, 0);
                chk("mrst_inj_ready", inj_TREADY, 0);
                chk("mrst_req_ready", req_ready, 0);
                chk("mrst_busy", busy, 0);
                chk("mrst_errs", {err_len, err_timeout}, 0);
                chk("mrst_stats", {stat_cmds, stat_flits}, 0);
                exp_q.delete();
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("post_rst_req_ready", req_ready, 1);
                chk("post_rst_busy", busy, 0);
                chk("post_rst_stat_cmds", stat_cmds, 0);
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
